// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
// Key codes follow the keypad debouncer encoding; 4'hF means no key is pressed.
package vend_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCredit,
        StDispense,
        StChange
    } state_t;

    localparam logic [3:0] KEY_NONE   = 4'hF;
    localparam logic [3:0] KEY_C5     = 4'h0;
    localparam logic [3:0] KEY_C10    = 4'h1;
    localparam logic [3:0] KEY_C25    = 4'h2;
    localparam logic [3:0] KEY_SEL_A  = 4'hA;
    localparam logic [3:0] KEY_SEL_B  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_25 = 8'd25;

    function automatic logic [7:0] coin_value(input logic [3:0] key);
        logic [7:0] value;
        value = 8'd0;
        case (key)
            KEY_C5:  value = COIN_5;
            KEY_C10: value = COIN_10;
            KEY_C25: value = COIN_25;
            default: value = 8'd0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Key input and customer-facing outputs of the vending controller.
// The controller takes the slave side; the keypad/display environment is the master.
interface vend_controller_if;

    logic [3:0] key_code;
    logic [7:0] credit;
    logic       dispense_a;
    logic       dispense_b;
    logic [7:0] change;
    logic       change_valid;
    logic       reject;
    logic       busy;

    modport master (
        output key_code,
        input  credit,
        input  dispense_a,
        input  dispense_b,
        input  change,
        input  change_valid,
        input  reject,
        input  busy
    );

    modport slave (
        input  key_code,
        output credit,
        output dispense_a,
        output dispense_b,
        output change,
        output change_valid,
        output reject,
        output busy
    );

endinterface

// File: rtl/key_edge_detect.sv
// Turns a debounced key code into a one-cycle press strobe on the release-to-press edge.
// A held key, or a direct change between two keys, produces no strobe.
module key_edge_detect
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    output logic       press,
    output logic [3:0] press_code
);

    logic [3:0] key_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_prev <= KEY_NONE;
        end else begin
            key_prev <= key_code;
        end
    end

    // Combinational so the controller acts on the press at the detecting edge.
    assign press      = (key_code != KEY_NONE) && (key_prev == KEY_NONE);
    assign press_code = key_code;

endmodule

// File: rtl/vend_controller.sv
// Vending transaction FSM: accumulates coin credit, dispenses items and returns change.
// credit feeds the binary-to-BCD display path directly.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [7:0]  PRICE_A     = 8'd25,
    parameter logic [7:0]  PRICE_B     = 8'd50,
    parameter logic [7:0]  MAX_CREDIT  = 8'd200,
    parameter logic [25:0] DISP_CYCLES = 26'd50000000
) (
    input  logic               clk,
    input  logic               reset,
    vend_controller_if.slave   bus
);

    state_t      state;
    logic [7:0]  credit;
    logic        dispense_a;
    logic        dispense_b;
    logic [7:0]  change;
    logic        change_valid;
    logic        reject;
    logic        busy;
    logic [25:0] timer;

    logic        press;
    logic [3:0]  press_code;
    logic [8:0]  coin_sum;
    logic        accepting;
    logic        start_dispense;

    key_edge_detect u_key_edge_detect (
        .clk        (clk),
        .reset      (reset),
        .key_code   (bus.key_code),
        .press      (press),
        .press_code (press_code)
    );

    // Nine bits so an over-ceiling coin cannot wrap into an accepted value.
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_value(press_code)};
    assign accepting = press && ((state == StIdle) || (state == StCredit));
    assign start_dispense = accepting &&
                            (((press_code == KEY_SEL_A) && (credit >= PRICE_A)) ||
                             ((press_code == KEY_SEL_B) && (credit >= PRICE_B)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            credit       <= 8'd0;
            dispense_a   <= 1'b0;
            dispense_b   <= 1'b0;
            change       <= 8'd0;
            change_valid <= 1'b0;
            reject       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            change_valid <= 1'b0;
            reject       <= 1'b0;
            case (state)
                StIdle, StCredit: begin
                    if (press) begin
                        case (press_code)
                            KEY_C5, KEY_C10, KEY_C25: begin
                                if (coin_sum <= {1'b0, MAX_CREDIT}) begin
                                    credit <= coin_sum[7:0];
                                    state  <= StCredit;
                                end else begin
                                    reject <= 1'b1;
                                end
                            end
                            KEY_SEL_A: begin
                                if (credit >= PRICE_A) begin
                                    credit     <= credit - PRICE_A;
                                    dispense_a <= 1'b1;
                                    state      <= StDispense;
                                    busy       <= 1'b1;
                                end else begin
                                    reject <= 1'b1;
                                end
                            end
                            KEY_SEL_B: begin
                                if (credit >= PRICE_B) begin
                                    credit     <= credit - PRICE_B;
                                    dispense_b <= 1'b1;
                                    state      <= StDispense;
                                    busy       <= 1'b1;
                                end else begin
                                    reject <= 1'b1;
                                end
                            end
                            KEY_CANCEL: begin
                                if (credit != 8'd0) begin
                                    change       <= credit;
                                    change_valid <= 1'b1;
                                    credit       <= 8'd0;
                                    state        <= StChange;
                                    busy         <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StDispense: begin
                    if (timer == 26'd0) begin
                        dispense_a <= 1'b0;
                        dispense_b <= 1'b0;
                        if (credit != 8'd0) begin
                            change       <= credit;
                            change_valid <= 1'b1;
                            credit       <= 8'd0;
                            state        <= StChange;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
                StChange: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Loaded with DISP_CYCLES-1 so the strobe spans exactly DISP_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= 26'd0;
        end else if (start_dispense) begin
            timer <= DISP_CYCLES - 26'd1;
        end else if ((state == StDispense) && (timer != 26'd0)) begin
            timer <= timer - 26'd1;
        end
    end

    assign bus.credit       = credit;
    assign bus.dispense_a   = dispense_a;
    assign bus.dispense_b   = dispense_b;
    assign bus.change       = change;
    assign bus.change_valid = change_valid;
    assign bus.reject       = reject;
    assign bus.busy         = busy;

endmodule
